// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU issue controller.
//   fpu_ctrl_state_t - issue controller FSM states
//   RM_*             - rounding-mode encodings (RM_DYN selects fcsr.frm)
//   FLAG_*           - bit positions of the exception flags in fflags
//   fcsr_t           - packed {frm, fflags} view of the fcsr register
package fpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWb,
        StResp
    } fpu_ctrl_state_t;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef struct packed {
        logic [2:0] frm;
        logic [4:0] fflags;
    } fcsr_t;

    // Encodings 5..7 are reserved once the dynamic mode has been resolved.
    function automatic logic rm_is_legal(input logic [2:0] rm);
        return rm <= RM_RMM;
    endfunction

endpackage

// File: rtl/fpu_fcsr_reg.sv
// fpu_fcsr_reg: the fcsr register (frm + sticky fflags).
//   clk, n_rst   - clock, asynchronous active-low reset
//   csr_we_i     - software write of the whole register
//   csr_wdata_i  - {frm, fflags} write data
//   acc_en_i     - accumulate acc_flags_i into fflags (write-back cycle)
//   acc_flags_i  - flags raised by the completing operation
//   frm_o        - current rounding mode
//   fflags_o     - current sticky exception flags
module fpu_fcsr_reg
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       csr_we_i,
    input  logic [7:0] csr_wdata_i,
    input  logic       acc_en_i,
    input  logic [4:0] acc_flags_i,
    output logic [2:0] frm_o,
    output logic [4:0] fflags_o
);

    fcsr_t fcsr_q, fcsr_d;
    fcsr_t wdata;
    logic [4:0] acc_flags;

    assign wdata     = fcsr_t'(csr_wdata_i);
    assign acc_flags = acc_en_i ? acc_flags_i : 5'b0;

    // A software write on the write-back cycle must not lose the op's flags,
    // so the accumulated flags are OR-ed on top of the written value.
    always_comb begin
        fcsr_d = fcsr_q;
        if (csr_we_i) begin
            fcsr_d.frm    = wdata.frm;
            fcsr_d.fflags = wdata.fflags | acc_flags;
        end else begin
            fcsr_d.fflags = fcsr_q.fflags | acc_flags;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fcsr_q <= '0;
        end else begin
            fcsr_q <= fcsr_d;
        end
    end

    assign frm_o    = fcsr_q.frm;
    assign fflags_o = fcsr_q.fflags;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-issue sequencer between execute and the FPU.
//   clk, n_rst            - clock, asynchronous active-low reset
//   req_*                 - valid/ready request: op, rounding field, registers
//   flush                 - abort the in-flight operation (ISSUE/WAIT only)
//   fpu_start             - one-cycle launch pulse to the FPU
//   fpu_funct7/frm/rs*/rd - latched operation fields, held ISSUE..WB
//   fpu_ready, fpu_flags  - FPU result valid and its exception flags
//   fpu_wen               - FP register-file write enable
//   resp_valid            - completion pulse, qualified by resp_illegal/resp_timeout
//   busy                  - controller not idle
//   csr_we, csr_wdata     - fcsr write port; csr_rdata - current fcsr
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned MAX_LAT = 16,
    parameter int unsigned CNT_W   = $clog2(MAX_LAT) + 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_funct7,
    input  logic [2:0] req_rm,
    input  logic [4:0] req_rs1,
    input  logic [4:0] req_rs2,
    input  logic [4:0] req_rd,
    input  logic       flush,
    output logic       fpu_start,
    output logic [6:0] fpu_funct7,
    output logic [2:0] fpu_frm,
    output logic [4:0] fpu_rs1,
    output logic [4:0] fpu_rs2,
    output logic [4:0] fpu_rd,
    input  logic       fpu_ready,
    input  logic [4:0] fpu_flags,
    output logic       fpu_wen,
    output logic       resp_valid,
    output logic       resp_illegal,
    output logic       resp_timeout,
    output logic       busy,
    input  logic       csr_we,
    input  logic [7:0] csr_wdata,
    output logic [7:0] csr_rdata
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_LAT - 1);

    fpu_ctrl_state_t state_q, state_d;
    logic [6:0]       funct7_q, funct7_d;
    logic [2:0]       frm_q, frm_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [4:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [2:0] csr_frm;
    logic [4:0] csr_fflags;
    logic [2:0] rm_eff;
    logic       in_wb;

    // Dynamic mode reads fcsr.frm at acceptance; later CSR writes cannot
    // reach the latched copy.
    assign rm_eff = (req_rm == RM_DYN) ? csr_frm : req_rm;

    always_comb begin
        state_d   = state_q;
        funct7_d  = funct7_q;
        frm_d     = frm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (!rm_is_legal(rm_eff)) begin
                        illegal_d = 1'b1;
                        timeout_d = 1'b0;
                        state_d   = StResp;
                    end else begin
                        funct7_d = req_funct7;
                        frm_d    = rm_eff;
                        rs1_d    = req_rs1;
                        rs2_d    = req_rs2;
                        rd_d     = req_rd;
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (fpu_ready) begin
                    flags_d = fpu_flags;
                    state_d = StWb;
                end else if (cnt_q == CntLast) begin
                    illegal_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWb:    state_d = StIdle;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            funct7_q  <= '0;
            frm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            flags_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct7_q  <= funct7_d;
            frm_q     <= frm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign in_wb = (state_q == StWb);

    fpu_fcsr_reg u_fcsr (
        .clk         (clk),
        .n_rst       (n_rst),
        .csr_we_i    (csr_we),
        .csr_wdata_i (csr_wdata),
        .acc_en_i    (in_wb),
        .acc_flags_i (flags_q),
        .frm_o       (csr_frm),
        .fflags_o    (csr_fflags)
    );

    assign req_ready    = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    // A flush in ISSUE suppresses the launch in that same cycle.
    assign fpu_start    = (state_q == StIssue) && !flush;
    assign fpu_wen      = in_wb;
    assign resp_valid   = in_wb || (state_q == StResp);
    assign resp_illegal = (state_q == StResp) && illegal_q;
    assign resp_timeout = (state_q == StResp) && timeout_q;
    assign fpu_funct7   = funct7_q;
    assign fpu_frm      = frm_q;
    assign fpu_rs1      = rs1_q;
    assign fpu_rs2      = rs2_q;
    assign fpu_rd       = rd_q;
    assign csr_rdata    = {csr_frm, csr_fflags};

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: cycle-stamped transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fpu_issue_ctrl;

    localparam int MAX_LAT = 16;
    localparam int KPend = 0, KWb = 1, KIll = 2, KTo = 3;

    logic       clk, n_rst;
    logic       req_valid, req_ready;
    logic [6:0] req_funct7;
    logic [2:0] req_rm;
    logic [4:0] req_rs1, req_rs2, req_rd;
    logic       flush, fpu_start;
    logic [6:0] fpu_funct7;
    logic [2:0] fpu_frm;
    logic [4:0] fpu_rs1, fpu_rs2, fpu_rd;
    logic       fpu_ready;
    logic [4:0] fpu_flags;
    logic       fpu_wen, resp_valid, resp_illegal, resp_timeout, busy;
    logic       csr_we;
    logic [7:0] csr_wdata, csr_rdata;

    fpu_issue_ctrl #(.MAX_LAT(MAX_LAT)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct7   (req_funct7),
        .req_rm       (req_rm),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_rd       (req_rd),
        .flush        (flush),
        .fpu_start    (fpu_start),
        .fpu_funct7   (fpu_funct7),
        .fpu_frm      (fpu_frm),
        .fpu_rs1      (fpu_rs1),
        .fpu_rs2      (fpu_rs2),
        .fpu_rd       (fpu_rd),
        .fpu_ready    (fpu_ready),
        .fpu_flags    (fpu_flags),
        .fpu_wen      (fpu_wen),
        .resp_valid   (resp_valid),
        .resp_illegal (resp_illegal),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_start = 0, tb_cyc = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation is a record with absolute cycle stamps for its
    // launch, its wait window and its completion.
    bit         m_act = 0;
    int         m_kind = KPend, m_start = -1, m_lo = 0, m_hi = 0, m_done = -1, cyc = 0;
    logic [6:0] m_f7 = '0;
    logic [2:0] m_frm = '0;
    logic [4:0] m_rs1 = '0, m_rs2 = '0, m_rd = '0, m_flags = '0;
    logic [7:0] m_fcsr = '0;

    always @(posedge clk or negedge n_rst) begin
        logic [4:0] add;
        logic [2:0] rm;
        if (!n_rst) begin
            m_act = 0; m_kind = KPend; m_done = -1; m_start = -1; m_fcsr = '0; cyc = 0;
        end else begin
            add = '0;
            if (m_act) begin
                if (m_kind != KPend && cyc == m_done) begin
                    m_act = 0;
                    if (m_kind == KWb) add = m_flags;
                end else if (m_kind == KPend) begin
                    if (flush) m_act = 0;
                    else if (cyc >= m_lo && fpu_ready) begin
                        m_kind = KWb; m_flags = fpu_flags; m_done = cyc + 1;
                    end else if (cyc == m_hi) begin
                        m_kind = KTo; m_done = cyc + 1;
                    end
                end
            end else if (req_valid) begin
                rm = (req_rm == 3'd7) ? m_fcsr[7:5] : req_rm;
                m_act = 1;
                if (rm >= 3'd5) begin
                    m_kind = KIll; m_done = cyc + 1; m_start = -1;
                end else begin
                    m_kind = KPend; m_f7 = req_funct7; m_frm = rm;
                    m_rs1 = req_rs1; m_rs2 = req_rs2; m_rd = req_rd;
                    m_start = cyc + 1; m_lo = cyc + 2; m_hi = cyc + 1 + MAX_LAT;
                end
            end
            if (csr_we) m_fcsr = {csr_wdata[7:5], csr_wdata[4:0] | add};
            else m_fcsr[4:0] = m_fcsr[4:0] | add;
            cyc++;
        end
    end

    always @(negedge clk) begin
        bit done;
        if (fpu_start) n_start++;
        if (chk_en) begin
            done = m_act && m_kind != KPend && cyc == m_done;
            chk("req_ready", req_ready, !m_act);
            chk("busy", busy, m_act);
            chk("fpu_start", fpu_start, m_act && m_kind == KPend && cyc == m_start && !flush);
            chk("fpu_wen", fpu_wen, done && m_kind == KWb);
            chk("resp_valid", resp_valid, done);
            chk("resp_illegal", resp_illegal, done && m_kind == KIll);
            chk("resp_timeout", resp_timeout, done && m_kind == KTo);
            chk("csr_rdata", csr_rdata, m_fcsr);
            if (m_act && m_kind != KIll) begin
                chk("fpu_funct7", fpu_funct7, m_f7);
                chk("fpu_frm", fpu_frm, m_frm);
                chk("fpu_rs1", fpu_rs1, m_rs1);
                chk("fpu_rs2", fpu_rs2, m_rs2);
                chk("fpu_rd", fpu_rd, m_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic csr_write(input logic [7:0] v);
        csr_we = 1'b1; csr_wdata = v;
        step();
        csr_we = 1'b0;
    endtask

    // Returns in the cycle after acceptance (ISSUE, or RESP if illegal).
    task automatic send(input logic [6:0] f7, input logic [2:0] rm,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        int guard = 0;
        while (!req_ready && guard < 64) begin step(); guard++; end
        chk("send_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_funct7 = f7; req_rm = rm;
        req_rs1 = a; req_rs2 = b; req_rd = d;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int s0, waits, n_acc, guard;
        int acc [2];
        req_valid = 0; req_funct7 = '0; req_rm = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        flush = 0; fpu_ready = 0; fpu_flags = '0; csr_we = 0; csr_wdata = '0;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        chk_en = 1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_csr", csr_rdata, 8'h00);

        // Basic op, ready on the second WAIT cycle.
        s0 = n_start;
        send(7'h00, 3'd0, 5'd1, 5'd2, 5'd3);
        chk("basic_start", fpu_start, 1'b1);
        step(); step();
        fpu_ready = 1; fpu_flags = 5'b00001;
        step();
        fpu_ready = 0; fpu_flags = '0;
        chk("basic_wen", fpu_wen, 1'b1);
        chk("basic_resp", resp_valid, 1'b1);
        chk("basic_rd", fpu_rd, 5'd3);
        chk("basic_frm", fpu_frm, 3'd0);
        step();
        chk("basic_csr", csr_rdata, 8'h01);
        chk("basic_nstart", n_start - s0, 1);

        // Dynamic rounding mode, sampled at acceptance.
        csr_write(8'h60);
        send(7'h04, 3'd7, 5'd4, 5'd5, 5'd6);
        chk("dyn_frm", fpu_frm, 3'd3);
        csr_write(8'h20);
        chk("dyn_frm_hold", fpu_frm, 3'd3);
        fpu_ready = 1;
        step();
        fpu_ready = 0;
        chk("dyn_wen", fpu_wen, 1'b1);
        step();
        chk("dyn_csr", csr_rdata, 8'h20);
        csr_write(8'hA0);
        s0 = n_start;
        send(7'h08, 3'd7, 5'd7, 5'd8, 5'd9);
        chk("ill_resp", resp_valid, 1'b1);
        chk("ill_flag", resp_illegal, 1'b1);
        chk("ill_wen", fpu_wen, 1'b0);
        step();
        chk("ill_csr", csr_rdata, 8'hA0);
        chk("ill_nstart", n_start - s0, 0);
        csr_write(8'h00);

        // Timeout after MAX_LAT WAIT cycles.
        send(7'h10, 3'd1, 5'd10, 5'd11, 5'd12);
        waits = 0;
        step();
        while (!resp_valid && waits < 40) begin waits++; step(); end
        chk("to_waits", waits, MAX_LAT);
        chk("to_flag", resp_timeout, 1'b1);
        chk("to_wen", fpu_wen, 1'b0);
        step();
        fpu_ready = 1; fpu_flags = 5'b11111;
        step();
        fpu_ready = 0; fpu_flags = '0;
        chk("late_ready_idle", busy, 1'b0);

        // Flush in WAIT, then a stale ready.
        send(7'h20, 3'd2, 5'd13, 5'd14, 5'd15);
        step();
        flush = 1;
        step();
        flush = 0; fpu_ready = 1; fpu_flags = 5'b11111;
        chk("flush_ready", req_ready, 1'b1);
        chk("flush_resp", resp_valid, 1'b0);
        step();
        fpu_ready = 0; fpu_flags = '0;
        chk("flush_wen", fpu_wen, 1'b0);
        chk("flush_csr", csr_rdata, 8'h00);

        // Flush in ISSUE suppresses the start pulse.
        s0 = n_start;
        send(7'h21, 3'd4, 5'd16, 5'd17, 5'd18);
        flush = 1;
        step();
        flush = 0;
        chk("flush_iss_ready", req_ready, 1'b1);
        chk("flush_iss_nstart", n_start - s0, 0);

        // CSR write colliding with write-back.
        csr_write(8'h10);
        send(7'h30, 3'd0, 5'd19, 5'd20, 5'd21);
        step();
        fpu_ready = 1; fpu_flags = 5'b00100;
        step();
        fpu_ready = 0; fpu_flags = '0;
        chk("coll_wen", fpu_wen, 1'b1);
        csr_write(8'h02);
        chk("coll_csr", csr_rdata, 8'h06);

        // Back-to-back requests with an always-ready FPU.
        fpu_ready = 1;
        req_valid = 1; req_funct7 = 7'h40; req_rm = 3'd0;
        req_rs1 = 5'd22; req_rs2 = 5'd23; req_rd = 5'd24;
        n_acc = 0; guard = 0;
        while (n_acc < 2 && guard < 30) begin
            if (req_ready) begin acc[n_acc] = tb_cyc; n_acc++; end
            step();
            guard++;
        end
        req_valid = 0;
        repeat (3) step();
        fpu_ready = 0;
        chk("b2b_count", n_acc, 2);
        chk("b2b_gap", acc[1] - acc[0], 4);

        // Reset in WAIT.
        send(7'h50, 3'd0, 5'd25, 5'd26, 5'd27);
        step();
        #2 n_rst = 1'b0;
        #1;
        chk("rstw_ready", req_ready, 1'b1);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_wen", fpu_wen, 1'b0);
        chk("rstw_resp", resp_valid, 1'b0);
        chk("rstw_start", fpu_start, 1'b0);
        chk("rstw_rd", fpu_rd, 5'd0);
        chk("rstw_f7", fpu_funct7, 7'd0);
        chk("rstw_csr", csr_rdata, 8'h00);
        step(); step();
        n_rst = 1'b1;
        step();
        chk("rstw_after", req_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequences single-issue operations from the integer pipeline into the FPU datapath and FP register file.
- Accepts one request per valid/ready handshake, resolves the rounding mode (static or dynamic from fcsr.frm), pulses start, waits for f_ready with a timeout, then issues the register-file write enable.
- Owns the fcsr register (frm[7:5], fflags[4:0]) and accumulates sticky exception flags.
- Sits between the decode/execute stage and the FPU top level.

Parameters:
- MAX_LAT, 16, cycles waited in WAIT before a timeout is declared (minimum 2).
- CNT_W, $clog2(MAX_LAT)+1, width of the wait counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_funct7  in  7  FPU operation select
- req_rm  in  3  instruction rounding field; 3'b111 means dynamic
- req_rs1, req_rs2, req_rd  in  5 each  register selects
- flush  in  1  abort the in-flight operation
- fpu_start  out  1  one-cycle launch pulse
- fpu_funct7  out  7  latched op
- fpu_frm  out  3  resolved rounding mode
- fpu_rs1, fpu_rs2, fpu_rd  out  5 each  latched selects
- fpu_ready  in  1  FPU result valid
- fpu_flags  in  5  NV,DZ,OF,UF,NX; valid with fpu_ready
- fpu_wen  out  1  FP register-file write enable
- resp_valid  out  1  one-cycle completion pulse
- resp_illegal  out  1  qualifies resp_valid: illegal rounding mode
- resp_timeout  out  1  qualifies resp_valid: FPU did not answer
- busy  out  1  state != IDLE
- csr_we  in  1  fcsr write
- csr_wdata  in  8  {frm, fflags}
- csr_rdata  out  8  current fcsr

Behaviour:
- Clock and reset: one clock, clk. n_rst is asynchronous and active-low.
- Reset values: state=IDLE, fcsr=0, all latched fields=0, counter=0, every 1-bit output 0 except req_ready=1.
- States: IDLE, ISSUE, WAIT, WB, RESP.
- req_ready = (state==IDLE). Acceptance = req_valid & req_ready.
- IDLE, on acceptance:
  - rm_eff = (req_rm==7) ? fcsr.frm : req_rm.
  - If rm_eff is 5, 6 or 7: go to RESP with illegal=1. No FPU start; fcsr unchanged.
  - Otherwise latch funct7, rs1, rs2, rd and rm_eff, then go to ISSUE.
- ISSUE: fpu_start=1 for exactly one cycle; counter cleared; go to WAIT.
- WAIT:
  - fpu_ready=1: latch fpu_flags, go to WB.
  - Otherwise, if counter==MAX_LAT-1: go to RESP with timeout=1.
  - Otherwise counter++.
  - fpu_ready takes priority over timeout in the same cycle.
- WB: fpu_wen=1, resp_valid=1; fcsr.fflags |= latched flags; go to IDLE.
- RESP: resp_valid=1 with the illegal or timeout qualifier; fpu_wen=0; go to IDLE.
- fpu_* operand outputs hold their latched values from ISSUE through WB.
- Minimum latency: accept at cycle 0, start at 1, ready at 2, wen/resp at 3, next accept at 4.
- flush in ISSUE or WAIT:
  - Return to IDLE next cycle; no fpu_start if in ISSUE.
  - No wen, no resp, no flag update.
  - flush in IDLE, WB or RESP is ignored; WB completes normally.
- csr_we writes fcsr in any state. If it coincides with WB: fflags = csr_wdata[4:0] | latched flags; frm = csr_wdata[7:5].
- The dynamic rm is sampled at acceptance. A later CSR write does not affect the in-flight op.
- A late fpu_ready outside WAIT is ignored.
- n_rst assertion mid-operation returns to reset values immediately; no wen is emitted.

Decomposition:
- fpu_pkg:
  - state enum fpu_ctrl_state_t.
  - rounding constants RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7.
  - flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
  - fcsr_t packed struct {frm, fflags}.
- One sub-module, fpu_fcsr_reg: holds fcsr, arbitrates CSR write against WB flag accumulation, outputs frm and fflags.

Test Plan:
- Basic op: req funct7=7'h00, rm=0, rd=3; fpu_ready at 2nd WAIT cycle with flags=5'b00001 -> one start pulse; fpu_frm=0; wen and resp_valid in the same cycle with fpu_rd=3; csr_rdata=8'h01.
- Dynamic rm: csr write 8'h60 (frm=3), then req rm=7 -> fpu_frm=3. csr write frm=5, then req rm=7 -> resp_valid & resp_illegal, no start, fcsr unchanged.
- Timeout: MAX_LAT=16, fpu_ready never asserted -> resp_valid & resp_timeout exactly 16 WAIT cycles after start; wen=0.
- Flush: flush during WAIT, then fpu_ready the next cycle -> no wen, no resp; req_ready=1 next cycle; flags unchanged.
- CSR/WB collision: fflags=5'b10000, csr_we with 8'h02 in the same cycle as WB with flags 5'b00100 -> csr_rdata=8'h06.
- Back-to-back ops with reset: two ops back-to-back -> second accept no earlier than 4 cycles after first. Separately, assert n_rst in WAIT -> all outputs at reset values, req_ready=1.
